// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and constants for the multicycle control sequencer.
package multicycle_sequencer_pkg;

    // Sequencer states (3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_TRAP   = 3'd7
    } state_t;

    localparam int INSTRET_W = 32;

    // True for states that hold an outstanding memory request
    function automatic logic is_req_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Memory wait timer: counts unacknowledged request cycles and flags
// expiry when the last allowed cycle passes without an ack.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear outside request states, saturate at the last cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !ack_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack in the expiry cycle takes priority, so expiry is masked by it
    assign expired_o = en_i && !ack_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: steps each instruction through
// fetch/decode/execute/mem/writeback, drives datapath enables and
// memory handshakes, and counts retired instructions.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ld,
    input  logic                 i_st,
    input  logic                 i_rf_wr,
    input  logic                 i_illegal,
    input  logic                 i_halt,
    input  logic                 i_imem_ack,
    input  logic                 i_dmem_ack,
    output logic                 o_imem_req,
    output logic                 o_ir_load,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic                 o_mdr_load,
    output logic                 o_rf_we,
    output logic                 o_pc_en,
    output logic                 o_halted,
    output logic                 o_trap,
    output logic [INSTRET_W-1:0] o_instret
);

    state_t                 state_q;
    state_t                 state_d;
    logic [INSTRET_W-1:0]   instret_q;
    logic [INSTRET_W-1:0]   instret_d;

    logic                   tmr_clear;
    logic                   tmr_en;
    logic                   tmr_ack;
    logic                   tmr_expired;

    // The timer runs only while a request is outstanding; any other state
    // holds it at zero so it starts fresh on every FETCH or MEM entry.
    assign tmr_en    = is_req_state(state_q);
    assign tmr_clear = !tmr_en;
    assign tmr_ack   = (state_q == ST_FETCH) ? i_imem_ack :
                       (state_q == ST_MEM)   ? i_dmem_ack : 1'b0;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .clear_i   (tmr_clear),
        .en_i      (tmr_en),
        .ack_i     (tmr_ack),
        .expired_o (tmr_expired)
    );

    // State and retire-counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next state and per-state outputs; outputs depend only on the state,
    // except the latch strobes which follow the same-cycle ack.
    always_comb begin
        state_d    = state_q;
        instret_d  = instret_q;
        o_imem_req = 1'b0;
        o_ir_load  = 1'b0;
        o_dmem_req = 1'b0;
        o_dmem_we  = 1'b0;
        o_mdr_load = 1'b0;
        o_rf_we    = 1'b0;
        o_pc_en    = 1'b0;
        o_halted   = 1'b0;
        o_trap     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    o_ir_load = 1'b1;
                    state_d   = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                state_d = i_illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                state_d = (i_ld || i_st) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                o_dmem_req = 1'b1;
                o_dmem_we  = i_st;
                if (i_dmem_ack) begin
                    o_mdr_load = i_ld;
                    state_d    = ST_WB;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                // Stores never write the register file
                o_rf_we   = i_rf_wr && !i_st;
                o_pc_en   = 1'b1;
                instret_d = instret_q + 32'd1;
                state_d   = i_halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                o_halted = 1'b1;
                if (!i_halt) begin
                    state_d = ST_FETCH;
                end
            end
            ST_TRAP: begin
                o_trap = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_instret = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer (TIMEOUT = 4): a per-cycle
// vector table plus hand-written reset, trap and counter-wrap sequences.
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    logic        clk;
    logic        rst;
    logic        ld, st, rf_wr, illegal, halt, imem_ack, dmem_ack;
    logic        imem_req, ir_load, dmem_req, dmem_we, mdr_load;
    logic        rf_we, pc_en, halted, trap;
    logic [31:0] instret;

    int total = 0;
    int passed = 0;

    // Input bit positions {ld, st, rf_wr, illegal, halt, imem_ack, dmem_ack}
    localparam logic [6:0] LD = 7'h40, ST = 7'h20, RF = 7'h10, ILL = 7'h08;
    localparam logic [6:0] HLTI = 7'h04, IA = 7'h02, DA = 7'h01, NONE = 7'h00;
    // Output bit positions {imem_req, ir_load, dmem_req, dmem_we, mdr_load,
    //                       rf_we, pc_en, halted, trap}
    localparam logic [8:0] IREQ = 9'h100, IRL = 9'h080, DREQ = 9'h040;
    localparam logic [8:0] DWE = 9'h020, MDR = 9'h010, RFWE = 9'h008;
    localparam logic [8:0] PCEN = 9'h004, HLT = 9'h002, TRP = 9'h001, Z = 9'h000;

    typedef struct {
        logic [6:0]  in;
        logic [8:0]  exp;
        logic [31:0] exp_instret;
    } vec_t;

    vec_t vecs[$];

    multicycle_sequencer #(
        .TIMEOUT (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ld       (ld),
        .i_st       (st),
        .i_rf_wr    (rf_wr),
        .i_illegal  (illegal),
        .i_halt     (halt),
        .i_imem_ack (imem_ack),
        .i_dmem_ack (dmem_ack),
        .o_imem_req (imem_req),
        .o_ir_load  (ir_load),
        .o_dmem_req (dmem_req),
        .o_dmem_we  (dmem_we),
        .o_mdr_load (mdr_load),
        .o_rf_we    (rf_we),
        .o_pc_en    (pc_en),
        .o_halted   (halted),
        .o_trap     (trap),
        .o_instret  (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {imem_req, ir_load, dmem_req, dmem_we, mdr_load,
                rf_we, pc_en, halted, trap};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        {ld, st, rf_wr, illegal, halt, imem_ack, dmem_ack} = v;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic [6:0] in, input logic [8:0] exp, input logic [31:0] ir);
        vec_t v;
        v.in = in;
        v.exp = exp;
        v.exp_instret = ir;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        drive(NONE);

        // R-type, zero wait
        add(NONE,          Z,           0);  // IDLE
        add(IA | RF,       IREQ | IRL,  0);  // FETCH
        add(RF,            Z,           0);  // DECODE
        add(RF,            Z,           0);  // EXEC
        add(RF,            RFWE | PCEN, 0);  // WB
        // Load, dmem ack on 4th MEM cycle (ack beats expiry)
        add(IA | LD | RF,  IREQ | IRL,  1);
        add(LD | RF,       Z,           1);
        add(LD | RF,       Z,           1);
        add(LD | RF,       DREQ,        1);
        add(LD | RF,       DREQ,        1);
        add(LD | RF,       DREQ,        1);
        add(LD | RF | DA,  DREQ | MDR,  1);
        add(LD | RF,       RFWE | PCEN, 1);
        // Store, stray dmem ack during FETCH is ignored
        add(IA | DA | ST,  IREQ | IRL,  2);
        add(ST,            Z,           2);
        add(ST,            Z,           2);
        add(ST | DA,       DREQ | DWE,  2);
        add(ST | RF,       PCEN,        2);
        // Halt held outside WB has no effect until WB
        add(IA | HLTI,     IREQ | IRL,  3);
        add(HLTI | RF,     Z,           3);
        add(HLTI | RF,     Z,           3);
        add(HLTI | RF,     RFWE | PCEN, 3);
        add(HLTI,          HLT,         4);
        add(NONE,          HLT,         4);
        // Fetch with ack on the 4th cycle: no trap
        add(NONE,          IREQ,        4);
        add(NONE,          IREQ,        4);
        add(NONE,          IREQ,        4);
        add(IA,            IREQ | IRL,  4);
        add(NONE,          Z,           4);
        add(NONE,          Z,           4);
        add(NONE,          PCEN,        4);
        // Fetch never acked: trap after 4 cycles, then sticky
        add(NONE,          IREQ,        5);
        add(NONE,          IREQ,        5);
        add(NONE,          IREQ,        5);
        add(NONE,          IREQ,        5);
        add(IA,            TRP,         5);
        add(7'h7F,         TRP,         5);

        @(negedge clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'(Z));
        chk("reset_instret", instret, 32'd0);
        chk("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].in);
            #1;
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_instret", i), instret, vecs[i].exp_instret);
            cyc();
        end

        // Async reset out of TRAP clears immediately, before any clock edge
        drive(NONE);
        #1;
        chk("trap_before_rst", 32'(trap), 32'd1);
        rst = 1'b1;
        #1;
        chk("trap_async_clear", 32'(trap), 32'd0);
        chk("rst_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rst_instret_clr", instret, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Illegal in DECODE -> trap next cycle, sticky
        cyc();                         // now FETCH
        drive(IA);
        cyc();                         // now DECODE
        drive(ILL);
        #1;
        chk("decode_no_trap", 32'(trap), 32'd0);
        cyc();
        drive(IA | DA | HLTI);
        #1;
        chk("illegal_trap", 32'(outs()), 32'(TRP));
        cyc();
        cyc();
        chk("trap_sticky", 32'(outs()), 32'(TRP));

        // Reset mid-MEM drops the request with no PC/RF write
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(NONE);
        cyc();                         // FETCH
        drive(IA);
        cyc();                         // DECODE
        drive(ST | RF);
        cyc();                         // EXEC
        cyc();                         // MEM
        drive(ST | RF);
        #1;
        chk("mem_store_req", 32'(outs()), 32'(DREQ | DWE));
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", 32'(outs()), 32'(Z));
        chk("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        drive(NONE);
        #1;
        chk("mid_rst_instret", instret, 32'd0);

        // Retire counter wraps to zero
        cyc();                         // FETCH
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        chk("wrap_preload", instret, 32'hFFFF_FFFF);
        drive(IA | RF);
        cyc();                         // DECODE
        cyc();                         // EXEC
        cyc();                         // WB
        #1;
        chk("wrap_wb_outs", 32'(outs()), 32'(RFWE | PCEN));
        chk("wrap_wb_instret", instret, 32'hFFFF_FFFF);
        drive(NONE);
        cyc();                         // FETCH
        #1;
        chk("wrap_instret", instret, 32'd0);
        chk("wrap_fetch_outs", 32'(outs()), 32'(IREQ));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
